// File: rtl/boot_loader.sv
// Host byte-stream program loader: parses COUNT | words | CSUM, writes words into
// the CPU's RAM and releases cpu_rst only after a checksum-verified load.
module boot_loader #(
    parameter int SIZE      = 14,
    parameter int MAX_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_data,
    output logic            cpu_rst,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int          IDX_W = $clog2(MAX_WORDS) + 1;
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR
    } state_t;

    state_t           state;
    logic [15:0]      count;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      word_acc;
    logic [7:0]       csum_acc;

    logic             xfer;
    logic [15:0]      hdr_n;
    logic [IDX_W-1:0] idx_nxt;

    assign xfer    = in_valid & in_ready;
    assign hdr_n   = {count[15:8], in_data};
    assign idx_nxt = word_idx + 1'b1;

    // in_ready is registered from the next state, so it never depends on in_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HDR0;
            in_ready <= 1'b0;
            ram_wrEn <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            cpu_rst  <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_acc <= '0;
            csum_acc <= '0;
        end else begin
            ram_wrEn <= 1'b0;
            if (xfer)
                csum_acc <= csum_acc ^ in_data;

            unique case (state)
                HDR0: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        count <= {in_data, 8'h00};
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        count <= hdr_n;
                        if (hdr_n == 16'd0) begin
                            state <= CSUM;
                        end else if (hdr_n > MAX_N) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        word_acc <= {word_acc[15:0], in_data};
                        if (byte_idx == 2'd3) begin
                            ram_wrEn <= 1'b1;
                            ram_addr <= SIZE'(word_idx);
                            ram_data <= {word_acc, in_data};
                            in_ready <= 1'b0;
                            state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    word_idx <= idx_nxt;
                    in_ready <= 1'b1;
                    state    <= (16'(idx_nxt) == count) ? CSUM : DATA;
                end
                CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == csum_acc) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                DONE: in_ready <= 1'b0;
                ERR:  in_ready <= 1'b0;
                default: begin
                    state    <= ERR;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    err      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed + randomized bench for boot_loader: frames are built from random words,
// outcomes and RAM writes predicted from the frame bytes alone.
module tb_boot_loader;
    localparam int SIZE      = 14;
    localparam int MAX_WORDS = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [7:0]      in_data = 8'h00;
    logic            in_ready;
    logic            ram_wrEn;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_data;
    logic            cpu_rst;
    logic            busy;
    logic            done;
    logic            err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]      frame_q[$];
    int              hs_q[$];
    logic [SIZE-1:0] wr_addr_q[$];
    logic [31:0]     wr_data_q[$];
    int              wr_cyc_q[$];

    boot_loader #(.SIZE(SIZE), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ram_wrEn(ram_wrEn), .ram_addr(ram_addr),
        .ram_data(ram_data), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && ram_wrEn) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_data);
            wr_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_wrEn"},     64'(ram_wrEn), 64'd0);
        check({tag, "_addr"},     64'(ram_addr), 64'd0);
        check({tag, "_data"},     64'(ram_data), 64'd0);
        check({tag, "_cpu_rst"},  64'(cpu_rst),  64'd1);
        check({tag, "_busy"},     64'(busy),     64'd1);
        check({tag, "_done"},     64'(done),     64'd0);
        check({tag, "_err"},      64'(err),      64'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        hs_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    // Offer one byte after 'gap' idle cycles; records the cycle of its handshake.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                check("hs_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
        end
        hs_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic build(input logic [15:0] n, input int nw, input logic [7:0] flip, input bit fixed);
        logic [31:0] w;
        logic [7:0]  x;
        frame_q.delete();
        frame_q.push_back(n[15:8]);
        frame_q.push_back(n[7:0]);
        for (int k = 0; k < nw; k++) begin
            if (fixed) w = (k == 0) ? 32'h20114045 : 32'h10114001;
            else       w = $urandom;
            for (int j = 3; j >= 0; j--) frame_q.push_back(w[8*j +: 8]);
        end
        x = 8'h00;
        foreach (frame_q[i]) x ^= frame_q[i];
        frame_q.push_back(x ^ flip);
    endtask

    function automatic int gap_for(input int mode, input int i);
        if (mode == 0) return $urandom_range(0, 3);
        if (i >= 6 && ((i - 2) % 4) == 0) return 0;
        if (mode == 1) return 1;
        return 0;
    endfunction

    task automatic offer_ignored(input int cycles, input logic exp_done, input logic exp_err);
        int rdy_seen;
        int wr0;
        rdy_seen = 0;
        wr0      = wr_data_q.size();
        in_valid = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            if (in_ready) rdy_seen++;
        end
        in_valid = 1'b0;
        check("idle_ready_seen", 64'(rdy_seen), 64'd0);
        check("idle_new_writes", 64'(wr_data_q.size() - wr0), 64'd0);
        check("idle_done", 64'(done), 64'(exp_done));
        check("idle_err",  64'(err),  64'(exp_err));
    endtask

    // Reference: outcome and write list derived from the frame bytes alone.
    task automatic run_frame(input int mode);
        int          n;
        int          nbytes;
        int          nw;
        bit          good;
        logic [7:0]  x;
        logic [31:0] w;
        n = {frame_q[0], frame_q[1]};
        if (n > MAX_WORDS) begin
            nbytes = 2;
            nw     = 0;
            good   = 1'b0;
        end else begin
            nbytes = 3 + 4 * n;
            nw     = n;
            x      = 8'h00;
            for (int i = 0; i < nbytes - 1; i++) x ^= frame_q[i];
            good = (frame_q[nbytes-1] == x);
        end
        hs_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();

        for (int i = 0; i < nbytes; i++) send_byte(frame_q[i], gap_for(mode, i));
        @(negedge clk);

        check("end_done",     64'(done),     64'(good));
        check("end_err",      64'(err),      64'(!good));
        check("end_cpu_rst",  64'(cpu_rst),  64'(!good));
        check("end_busy",     64'(busy),     64'd0);
        check("end_in_ready", 64'(in_ready), 64'd0);
        check("hs_count",     64'(hs_q.size()), 64'(nbytes));
        check("wr_count",     64'(wr_data_q.size()), 64'(nw));
        if (wr_data_q.size() == nw && hs_q.size() == nbytes) begin
            for (int k = 0; k < nw; k++) begin
                w = {frame_q[2+4*k], frame_q[3+4*k], frame_q[4+4*k], frame_q[5+4*k]};
                check($sformatf("wr_addr%0d", k), 64'(wr_addr_q[k]), 64'(k));
                check($sformatf("wr_data%0d", k), 64'(wr_data_q[k]), 64'(w));
                check($sformatf("wr_cyc%0d", k), 64'(wr_cyc_q[k]), 64'(hs_q[5+4*k] + 1));
                if (mode != 0)
                    check($sformatf("write_stall%0d", k),
                          64'(hs_q[6+4*k] - hs_q[5+4*k]), 64'd2);
            end
        end
        offer_ignored(5, good, !good);
    endtask

    initial begin
        logic [7:0]  flip;
        logic [31:0] w0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #2;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_release", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("ready_first_clk", 64'(in_ready), 64'd1);
        check("busy_idle", 64'(busy), 64'd1);

        // Reference frame, good checksum
        do_reset();
        build(16'd2, 2, 8'h00, 1'b1);
        run_frame(2);

        // Reference frame, corrupted checksum
        do_reset();
        build(16'd2, 2, 8'h01, 1'b1);
        run_frame(2);

        // Empty image
        do_reset();
        build(16'd0, 0, 8'h00, 1'b0);
        check("empty_csum_byte", 64'(frame_q[2]), 64'd0);
        run_frame(2);

        // Oversized count
        do_reset();
        build(16'h0401, 0, 8'h00, 1'b0);
        run_frame(2);

        // Toggling valid, valid held through WRITE
        do_reset();
        build(16'd1, 1, 8'h00, 1'b0);
        run_frame(1);
        do_reset();
        build(16'd2, 2, 8'h00, 1'b0);
        run_frame(1);

        // Reset in the middle of the second word
        do_reset();
        build(16'd2, 2, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(frame_q[i], 0);
        w0 = {frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
        check("abort_busy",    64'(busy),    64'd1);
        check("abort_cpu_rst", 64'(cpu_rst), 64'd1);
        check("abort_word0",   64'(ram_data), 64'(w0));
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("rst_midload");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        build(16'd3, 3, 8'h00, 1'b0);
        run_frame(0);

        // Random frames with random gaps and occasional bad checksum
        for (int f = 0; f < 5; f++) begin
            do_reset();
            flip = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            begin
                int nw;
                nw = $urandom_range(1, 8);
                build(16'(nw), nw, flip, 1'b0);
            end
            run_frame(f % 3);
        end

        // Largest legal image
        do_reset();
        build(16'(MAX_WORDS), MAX_WORDS, 8'h00, 1'b0);
        run_frame(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
